// File: rtl/swerv_trace_event_fifo_if.sv
// ---------------------------------------------------------------------------
// swerv_trace_event_fifo_if
//
// Record stream from the trace capture FIFO to the trace sink.
//
//   out_valid  source -> sink   a record is presented
//   out_ready  sink -> source   the sink takes the record this cycle
//   out_stage  source -> sink   pipeline stage code of the record
//   out_pc     source -> sink   PC of the record
//   out_ts     source -> sink   timestamp of the cycle the event was captured
//   out_lost   source -> sink   events were dropped just before this record
//
// master: the FIFO side (drives the record), slave: the sink side.
// ---------------------------------------------------------------------------
interface swerv_trace_event_fifo_if #(
  parameter int TS_W = 16
);
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_stage;
  logic [31:0]     out_pc;
  logic [TS_W-1:0] out_ts;
  logic            out_lost;

  modport master (
    output out_valid,
    output out_stage,
    output out_pc,
    output out_ts,
    output out_lost,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_stage,
    input  out_pc,
    input  out_ts,
    input  out_lost,
    output out_ready
  );
endinterface

// File: rtl/swerv_trace_event_fifo.sv
// ---------------------------------------------------------------------------
// swerv_trace_event_fifo
//
// Capture stage for SweRV EH1 microarchitectural trace events. Up to two
// stage events per cycle are timestamped with a free-running counter, queued
// in a first-word-fall-through FIFO and streamed to the sink one record per
// cycle. When the FIFO cannot take an event it is dropped, counted, and the
// next record that does get written carries a "lost" marker.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   ev0_* / ev1_*    lane-0 / lane-1 event taps (valid, stage code, PC);
//                    lane 0 is ordered before lane 1 within a cycle
//   finish_req       end-of-trace request; afterwards new events are ignored
//   out_if           record stream (master side of the interface)
//   level            current FIFO occupancy
//   drop_count       total dropped events, saturating
//   done             sticky: finish requested and FIFO fully drained
//
// DEPTH must be a power of two and at least 4 (pointers wrap naturally and
// the second write slot must never alias the first).
// ---------------------------------------------------------------------------
module swerv_trace_event_fifo #(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ev0_valid,
  input  logic [2:0]               ev0_stage,
  input  logic [31:0]              ev0_pc,
  input  logic                     ev1_valid,
  input  logic [2:0]               ev1_stage,
  input  logic [31:0]              ev1_pc,
  input  logic                     finish_req,
  swerv_trace_event_fifo_if.master out_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int EV_W  = 3 + 32;          // {pc, stage}
  localparam int REC_W = 1 + TS_W + EV_W; // {lost, ts, pc, stage}

  // Record field positions inside a stored entry.
  localparam int STAGE_LSB = 0;
  localparam int PC_LSB    = 3;
  localparam int TS_LSB    = EV_W;
  localparam int LOST_BIT  = REC_W - 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [REC_W-1:0]  mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              lost_pending_q, lost_pending_d;
  logic              finishing_q, finishing_d;
  logic              done_q, done_d;

  // -------------------------------------------------------------------------
  // Lane gathering. Once finishing is registered the taps are ignored
  // entirely: nothing is written and nothing is counted as dropped. Events in
  // the very cycle finish_req first appears are still taken because
  // finishing_q is not yet set.
  // -------------------------------------------------------------------------
  logic [1:0]      lane_raw_valid;
  logic [1:0]      lane_valid;
  logic [EV_W-1:0] lane_ev [2];

  assign lane_raw_valid = {ev1_valid, ev0_valid};
  assign lane_ev[0]     = {ev0_pc, ev0_stage};
  assign lane_ev[1]     = {ev1_pc, ev1_stage};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_valid[gi] = lane_raw_valid[gi] & ~finishing_q;
  end

  // -------------------------------------------------------------------------
  // Write / drop / pop arithmetic
  // -------------------------------------------------------------------------
  logic [LVL_W-1:0]  free_slots;
  logic [1:0]        n_req;
  logic [1:0]        n_acc;
  logic [1:0]        n_drop;
  logic              wr0_en, wr1_en;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [EV_W-1:0]   slot0_ev;
  logic [REC_W-1:0]  wr0_data, wr1_data;
  logic              pop;
  logic [DROP_W:0]   drop_sum;
  logic [REC_W-1:0]  head;
  logic              head_valid;

  assign head_valid = (level_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign pop        = head_valid & out_if.out_ready;

  always_comb begin
    // Space is judged on the occupancy at the start of the cycle; a pop in
    // the same cycle does not make room for an incoming event.
    free_slots = LVL_W'(DEPTH) - level_q;
    n_req      = {1'b0, lane_valid[0]} + {1'b0, lane_valid[1]};

    // At most two requests, so a shortfall can only mean 0 or 1 free slots.
    if (free_slots >= LVL_W'(n_req)) begin
      n_acc = n_req;
    end else begin
      n_acc = free_slots[1:0];
    end
    n_drop = n_req - n_acc;

    wr0_en    = (n_acc != 2'd0);
    wr1_en    = (n_acc == 2'd2);
    wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    // Slot 0 holds the oldest accepted event: lane 0 if present, otherwise
    // lane 1 on its own. Slot 1 is only used when both lanes are accepted.
    slot0_ev = lane_valid[0] ? lane_ev[0] : lane_ev[1];

    // The first record written after a loss carries the marker. A second
    // record in the same cycle follows it directly, so it never does.
    wr0_data = {lost_pending_q, ts_q, slot0_ev};
    wr1_data = {1'b0, ts_q, lane_ev[1]};

    wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(n_acc) - LVL_W'(pop);
    ts_d     = ts_q + TS_W'(1);

    // A drop always (re)arms the marker, even when lane 0 was written in the
    // same cycle: lane 0 already took the old marker, lane 1's loss has to
    // be reported on the next record.
    if (n_drop != 2'd0) begin
      lost_pending_d = 1'b1;
    end else if (wr0_en) begin
      lost_pending_d = 1'b0;
    end else begin
      lost_pending_d = lost_pending_q;
    end

    drop_sum = {1'b0, drop_count_q} + (DROP_W + 1)'(n_drop);
    if (drop_sum[DROP_W]) begin
      drop_count_d = '1;
    end else begin
      drop_count_d = drop_sum[DROP_W-1:0];
    end

    // done looks at the next-state values so that it rises right after the
    // last pop (or right after finish_req when already empty).
    finishing_d = finishing_q | finish_req;
    done_d      = done_q | (finishing_d & (level_d == '0));
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      ts_q           <= '0;
      drop_count_q   <= '0;
      lost_pending_q <= 1'b0;
      finishing_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      ts_q           <= ts_d;
      drop_count_q   <= drop_count_d;
      lost_pending_q <= lost_pending_d;
      finishing_q    <= finishing_d;
      done_q         <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Record storage. Contents are not reset: stale entries are unreachable
  // once the pointers and level are cleared, and the outputs are masked
  // while the FIFO is empty.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      mem_q[wr_ptr_q] <= wr0_data;
    end
    if (wr1_en) begin
      mem_q[wr_ptr_p1] <= wr1_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The head entry falls through combinationally; it only changes
  // on a pop, so it holds while the sink stalls.
  // -------------------------------------------------------------------------
  assign out_if.out_valid = head_valid;
  assign out_if.out_stage = head_valid ? head[STAGE_LSB +: 3]  : 3'd0;
  assign out_if.out_pc    = head_valid ? head[PC_LSB +: 32]    : 32'd0;
  assign out_if.out_ts    = head_valid ? head[TS_LSB +: TS_W]  : '0;
  assign out_if.out_lost  = head_valid ? head[LOST_BIT]        : 1'b0;

  assign level      = level_q;
  assign drop_count = drop_count_q;
  assign done       = done_q;

endmodule
